// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial A+B+cin adder, one bit per clock, with IDLE/RUN/DONE control
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic [1:0]       state;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             s1, c1, s2, c2;
  half_adder ha0 (.a(a_q[0]), .b(b_q[0]), .s(s1), .c(c1));
  half_adder ha1 (.a(s1), .b(carry_q), .s(s2), .c(c2));
  assign o_busy  = state == RUN;
  assign o_done  = state == DONE;
  assign o_sum   = sum_q;
  assign o_carry = carry_q;
  // Control FSM plus operand/sum shift registers; the sum fills from the MSB side so it lands aligned after WIDTH bits
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
    end else if (state == IDLE) begin
      if (i_start) begin
        state   <= RUN;
        a_q     <= i_a;
        b_q     <= i_b;
        carry_q <= i_cin;
        cnt     <= '0;
      end
    end else if (state == RUN) begin
      sum_q   <= {s2, sum_q[WIDTH-1:1]};
      carry_q <= c1 | c2;
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      cnt     <= cnt == LAST ? cnt : cnt + 1'b1;
      state   <= cnt == LAST ? DONE : RUN;
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and random checks of serial_add_ctrl against an arithmetic reference
module tb_serial_add_ctrl;
  localparam int W = 8;
  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic [W-1:0] i_a = '0;
  logic [W-1:0] i_b = '0;
  logic         i_cin = 1'b0;
  logic         o_busy, o_done, o_carry;
  logic [W-1:0] o_sum;
  int checks = 0;
  int failures = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_a(i_a), .i_b(i_b),
    .i_cin(i_cin), .o_busy(o_busy), .o_done(o_done), .o_sum(o_sum), .o_carry(o_carry)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives a start, optionally pokes a stray start during RUN, checks latency and result.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input int pulse_at, input string tag);
    logic [W:0] ref_val;
    int cyc, busy_n;
    ref_val = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    i_start = 1'b1; i_a = a; i_b = b; i_cin = cin;
    @(negedge i_clk);
    cyc = 0; busy_n = 0;
    while (o_done !== 1'b1 && cyc < W + 10) begin
      if (o_busy === 1'b1) busy_n++;
      i_start = (cyc == pulse_at);
      if (cyc == pulse_at) begin
        i_a = '1; i_b = '1; i_cin = 1'b1;
      end
      @(negedge i_clk);
      cyc++;
    end
    i_start = 1'b0;
    chk({tag, "_done"}, {31'd0, o_done}, 32'd1);
    chk({tag, "_busy_cycles"}, busy_n, W);
    chk({tag, "_sum"}, o_sum, ref_val[W-1:0]);
    chk({tag, "_carry"}, o_carry, ref_val[W]);
    @(negedge i_clk);
    chk({tag, "_done_one_cycle"}, {31'd0, o_done}, 32'd0);
    chk({tag, "_sum_hold"}, {o_carry, o_sum}, ref_val);
  endtask

  initial begin
    int dones, gap, cyc;
    logic [W:0] prev;
    #1;
    chk("reset_busy", o_busy, 0);
    chk("reset_done", o_done, 0);
    chk("reset_sum", o_sum, 0);
    chk("reset_carry", o_carry, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    // First edge after reset release accepts the start.
    run_op(8'h00, 8'h00, 1'b0, -1, "zero");
    run_op(8'hFF, 8'h01, 1'b0, -1, "ff_plus_1");
    run_op(8'h7F, 8'h01, 1'b0, -1, "7f_plus_1");
    run_op(8'hA5, 8'h5A, 1'b1, -1, "a5_5a_c");
    run_op(8'h3C, 8'h0F, 1'b1, -1, "3c_0f_c");
    run_op(8'h12, 8'h34, 1'b0, 3, "ignore_start");
    dones = 0;
    repeat (W + 3) begin
      @(negedge i_clk);
      if (o_done === 1'b1) dones++;
    end
    chk("ignore_start_not_queued", dones, 0);
    // Abort with reset during RUN bit 4.
    i_start = 1'b1; i_a = 8'hC3; i_b = 8'h3C; i_cin = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (4) @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    chk("abort_busy", o_busy, 0);
    chk("abort_done", o_done, 0);
    chk("abort_sum", o_sum, 0);
    chk("abort_carry", o_carry, 0);
    dones = 0;
    @(negedge i_clk);
    if (o_done === 1'b1) dones++;
    chk("abort_no_done", dones, 0);
    i_rst_n = 1'b1;
    run_op(8'h01, 8'h02, 1'b0, -1, "after_abort");
    for (int i = 0; i < 20; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), (i % 4 == 0) ? int'($urandom_range(0, W - 1)) : -1, "rand");
    // Back-to-back: start held high.
    i_start = 1'b1; i_a = 8'h80; i_b = 8'h80; i_cin = 1'b0;
    prev = '0;
    gap = 0; dones = 0; cyc = 0;
    while (dones < 4 && cyc < 8 * (W + 2)) begin
      @(negedge i_clk);
      cyc++; gap++;
      if (o_done === 1'b1) begin
        chk("b2b_sum", {o_carry, o_sum}, 9'h100);
        if (dones > 0) chk("b2b_period", gap, W + 2);
        dones++;
        gap = 0;
      end
    end
    chk("b2b_pulses", dones, 4);
    i_start = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
